// File: rtl/meduram_wr_scheduler_if.sv
// Bus bundle for meduram_wr_scheduler: two valid/ready write request streams in,
// two registered RAM write ports out. The slave modport is the scheduler side.
interface meduram_wr_scheduler_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
);
  logic                  s1_valid;
  logic                  s1_ready;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;

  logic                  s2_valid;
  logic                  s2_ready;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [DATA_WIDTH-1:0] s2_data;

  logic                  wren1;
  logic [ADDR_WIDTH-1:0] wraddr1;
  logic [DATA_WIDTH-1:0] wrdata1;

  logic                  wren2;
  logic [ADDR_WIDTH-1:0] wraddr2;
  logic [DATA_WIDTH-1:0] wrdata2;

  modport master (
    output s1_valid, s1_addr, s1_data,
    output s2_valid, s2_addr, s2_data,
    input  s1_ready, s2_ready,
    input  wren1, wraddr1, wrdata1,
    input  wren2, wraddr2, wrdata2
  );

  modport slave (
    input  s1_valid, s1_addr, s1_data,
    input  s2_valid, s2_addr, s2_data,
    output s1_ready, s2_ready,
    output wren1, wraddr1, wrdata1,
    output wren2, wraddr2, wrdata2
  );
endinterface

// File: rtl/meduram_wr_scheduler.sv
// Write-side front end for the 2W/2R RAM: per-port FIFOs plus a collision-serializing
// scheduler (port 2 wins). Define MEDURAM_WRSCHED_CNT_EN to add the collision_cnt port.
module meduram_wr_scheduler #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic aclk,
  input  logic arstn,
  meduram_wr_scheduler_if.slave bus
`ifdef MEDURAM_WRSCHED_CNT_EN
  ,
  output logic [15:0] collision_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_P2_ONLY = 1'b1;

  logic [EW-1:0] mem1 [FIFO_DEPTH];
  logic [EW-1:0] mem2 [FIFO_DEPTH];
  logic [PW-1:0] wptr1, rptr1, wptr2, rptr2;
  logic [CW-1:0] cnt1, cnt2;

  logic                  push1, push2;
  logic                  hv1, hv2;
  logic [ADDR_WIDTH-1:0] head1_addr, head2_addr;
  logic [DATA_WIDTH-1:0] head1_data, head2_data;

  logic [0:0] state, state_nxt;
  logic       issue1, issue2, collide;

  // Ready comes only from registered occupancy, so there is no combinational pop-to-ready path.
  assign bus.s1_ready = (cnt1 != FULL);
  assign bus.s2_ready = (cnt2 != FULL);
  assign push1 = bus.s1_valid && bus.s1_ready;
  assign push2 = bus.s2_valid && bus.s2_ready;

  assign hv1 = (cnt1 != '0);
  assign hv2 = (cnt2 != '0);
  assign {head1_addr, head1_data} = mem1[rptr1];
  assign {head2_addr, head2_data} = mem2[rptr2];

  always_ff @(posedge aclk) begin
    if (push1) mem1[wptr1] <= {bus.s1_addr, bus.s1_data};
    if (push2) mem2[wptr2] <= {bus.s2_addr, bus.s2_data};
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wptr1 <= '0;
      rptr1 <= '0;
      cnt1  <= '0;
      wptr2 <= '0;
      rptr2 <= '0;
      cnt2  <= '0;
    end else begin
      if (push1)  wptr1 <= wptr1 + PW'(1);
      if (issue1) rptr1 <= rptr1 + PW'(1);
      if (push2)  wptr2 <= wptr2 + PW'(1);
      if (issue2) rptr2 <= rptr2 + PW'(1);
      case ({push1, issue1})
        2'b10:   cnt1 <= cnt1 + CW'(1);
        2'b01:   cnt1 <= cnt1 - CW'(1);
        default: cnt1 <= cnt1;
      endcase
      case ({push2, issue2})
        2'b10:   cnt2 <= cnt2 + CW'(1);
        2'b01:   cnt2 <= cnt2 - CW'(1);
        default: cnt2 <= cnt2;
      endcase
    end
  end

  // On a same-address collision port 1 goes first and port 2 follows alone next cycle,
  // so the later write (port 2) is the one that sticks.
  always_comb begin
    issue1    = 1'b0;
    issue2    = 1'b0;
    collide   = 1'b0;
    state_nxt = state;
    if (state == ST_RUN) begin
      if (hv1 && hv2 && (head1_addr == head2_addr)) begin
        issue1    = 1'b1;
        collide   = 1'b1;
        state_nxt = ST_P2_ONLY;
      end else begin
        issue1 = hv1;
        issue2 = hv2;
      end
    end else begin
      issue2    = hv2;
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state       <= ST_RUN;
      bus.wren1   <= 1'b0;
      bus.wraddr1 <= '0;
      bus.wrdata1 <= '0;
      bus.wren2   <= 1'b0;
      bus.wraddr2 <= '0;
      bus.wrdata2 <= '0;
    end else begin
      state     <= state_nxt;
      bus.wren1 <= issue1;
      bus.wren2 <= issue2;
      if (issue1) begin
        bus.wraddr1 <= head1_addr;
        bus.wrdata1 <= head1_data;
      end
      if (issue2) begin
        bus.wraddr2 <= head2_addr;
        bus.wrdata2 <= head2_data;
      end
    end
  end

`ifdef MEDURAM_WRSCHED_CNT_EN
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      collision_cnt <= '0;
    end else if (collide && (collision_cnt != 16'hFFFF)) begin
      collision_cnt <= collision_cnt + 16'd1;
    end
  end
`endif

endmodule
